// File: rtl/scroll_msg_arbiter.sv
// scroll_msg_arbiter
// Shares the strobe interface of a four-digit scrolling display between two
// byte-stream sources. A granted source gets a buffer clear, then its bytes
// are replayed as timed active-low data strobes. The finished message is held
// on screen before the next source is served.
//
// Build option: define SCROLL_ARB_PRIORITY_EN for fixed priority (source 0
// wins simultaneous requests). Left undefined, simultaneous requests are
// served round-robin.
//
// MAX_LEN must not exceed 31 because the byte counter is 5 bits wide.
module scroll_msg_arbiter #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned HOLD_CYCLES  = 24'd8388608,
    parameter int unsigned MAX_LEN      = 31
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  src_valid,
    input  logic [15:0] src_data,
    input  logic [1:0]  src_last,
    output logic [1:0]  src_ready,
    output logic [7:0]  ascii,
    output logic        dsn,
    output logic        clearn,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        drop
);

    typedef enum logic [2:0] {
        IDLE,
        CLR_LO,
        CLR_GAP,
        WAIT_BYTE,
        STB_LO,
        STB_GAP,
        HOLD
    } state_t;

    // One shared down-the-phase timer; 24 bits covers the hold interval.
    localparam int TIMER_W = 24;
    localparam logic [TIMER_W-1:0] PULSE_LAST = TIMER_W'(PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [4:0]         MAX_COUNT  = 5'(MAX_LEN);

    state_t              state;
    logic [TIMER_W-1:0]  timer;
    logic [4:0]          count;
    logic                last_flag;
    logic [1:0]          pick;
    logic                accept;
    logic [7:0]          byte_in;
    logic                last_in;

`ifndef SCROLL_ARB_PRIORITY_EN
    // Index of the source served most recently; reset to 1 so source 0 wins
    // the first contested request.
    logic                rr_ptr;
`endif

    // src_ready is only ever set for the granted source and only in WAIT_BYTE,
    // so a handshake on any bit is a handshake with the owner.
    assign accept  = |(src_valid & src_ready);
    assign byte_in = grant[1] ? src_data[15:8] : src_data[7:0];
    assign last_in = |(src_last & grant);

    // Choose which requester gets the display when leaving IDLE.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves pick
        // unassigned; a missing default in combinational logic infers a latch.
        pick = 2'b00;
`ifdef SCROLL_ARB_PRIORITY_EN
        if (src_valid[0]) begin
            pick = 2'b01;
        end else if (src_valid[1]) begin
            pick = 2'b10;
        end
`else
        if (src_valid == 2'b11) begin
            pick = rr_ptr ? 2'b01 : 2'b10;
        end else begin
            pick = src_valid;
        end
`endif
    end

    // Arbitration, clear, strobe-replay and hold sequencing with registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            timer     <= '0;
            count     <= '0;
            last_flag <= 1'b0;
            ascii     <= 8'h20;
            dsn       <= 1'b1;
            clearn    <= 1'b1;
            src_ready <= 2'b00;
            grant     <= 2'b00;
            busy      <= 1'b0;
            drop      <= 1'b0;
`ifndef SCROLL_ARB_PRIORITY_EN
            rr_ptr    <= 1'b1;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples pre-edge values, matching the hardware.
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pick) begin
                        grant  <= pick;
                        busy   <= 1'b1;
                        clearn <= 1'b0;
                        timer  <= '0;
                        state  <= CLR_LO;
`ifndef SCROLL_ARB_PRIORITY_EN
                        rr_ptr <= pick[1];
`endif
                    end
                end

                CLR_LO: begin
                    if (timer == PULSE_LAST) begin
                        clearn <= 1'b1;
                        timer  <= '0;
                        state  <= CLR_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                CLR_GAP: begin
                    if (timer == GAP_LAST) begin
                        count     <= '0;
                        timer     <= '0;
                        src_ready <= grant;
                        state     <= WAIT_BYTE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WAIT_BYTE: begin
                    if (accept) begin
                        if (count < MAX_COUNT) begin
                            ascii     <= byte_in;
                            last_flag <= last_in;
                            count     <= count + 1'b1;
                            src_ready <= 2'b00;
                            dsn       <= 1'b0;
                            timer     <= '0;
                            state     <= STB_LO;
                        end else begin
                            // Over-length byte: consumed and discarded. ascii keeps
                            // the last strobed character and ready stays up so the
                            // source can keep draining toward its last byte.
                            drop <= 1'b1;
                            if (last_in) begin
                                src_ready <= 2'b00;
                                timer     <= '0;
                                state     <= HOLD;
                            end
                        end
                    end
                end

                STB_LO: begin
                    if (timer == PULSE_LAST) begin
                        dsn   <= 1'b1;
                        timer <= '0;
                        state <= STB_GAP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                STB_GAP: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        if (last_flag) begin
                            state <= HOLD;
                        end else begin
                            src_ready <= grant;
                            state     <= WAIT_BYTE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                HOLD: begin
                    if (timer == HOLD_LAST) begin
                        grant <= 2'b00;
                        busy  <= 1'b0;
                        timer <= '0;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scroll_msg_arbiter.sv
// Testbench for scroll_msg_arbiter with short hold time (HOLD_CYCLES=16).
// Expected strobe bytes are queued when a source drives them and compared
// when the DUT starts each dsn pulse.
module tb_scroll_msg_arbiter;

    localparam int PULSE = 4;
    localparam int GAP   = 4;
    localparam int HOLD  = 16;
    localparam int MAXL  = 31;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [1:0]  src_valid = 2'b00;
    logic [15:0] src_data = 16'h0000;
    logic [1:0]  src_last = 2'b00;
    logic [1:0]  src_ready;
    logic [7:0]  ascii;
    logic        dsn;
    logic        clearn;
    logic [1:0]  grant;
    logic        busy;
    logic        drop;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [1:0] glog[$];
    int dsn_pulses = 0;
    int clr_pulses = 0;
    int drop_cnt = 0;
    int overlap_cnt = 0;
    bit len_chk_en = 1'b1;

    scroll_msg_arbiter #(
        .PULSE_CYCLES(PULSE),
        .GAP_CYCLES  (GAP),
        .HOLD_CYCLES (HOLD),
        .MAX_LEN     (MAXL)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .src_valid(src_valid),
        .src_data (src_data),
        .src_last (src_last),
        .src_ready(src_ready),
        .ascii    (ascii),
        .dsn      (dsn),
        .clearn   (clearn),
        .grant    (grant),
        .busy     (busy),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    // Output monitor: scoreboard pops, pulse widths, gaps and event counters.
    logic       dsn_q = 1'b1;
    logic       clr_q = 1'b1;
    logic [1:0] grant_q = 2'b00;
    int         low_len = 0;
    int         high_run = 1000;
    logic [7:0] stb_byte = 8'h00;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (!dsn && !clearn) overlap_cnt++;
        if (drop) drop_cnt++;
        if (grant != 2'b00 && grant_q == 2'b00) glog.push_back(grant);

        if (dsn && !dsn_q && len_chk_en) begin
            checks++;
            if (low_len !== PULSE) begin
                failures++;
                $display("FAIL dsn_width got=%0d want=%0d", low_len, PULSE);
            end
            checks++;
            if (ascii !== stb_byte) begin
                failures++;
                $display("FAIL ascii_stable got=%h want=%h", ascii, stb_byte);
            end
        end
        if (clearn && !clr_q && len_chk_en) begin
            checks++;
            if (low_len !== PULSE) begin
                failures++;
                $display("FAIL clearn_width got=%0d want=%0d", low_len, PULSE);
            end
        end

        if ((!dsn && dsn_q) || (!clearn && clr_q)) begin
            if (len_chk_en) begin
                checks++;
                if (high_run < GAP) begin
                    failures++;
                    $display("FAIL pulse_gap got=%0d want>=%0d", high_run, GAP);
                end
            end
            low_len = 0;
        end
        if (!dsn && dsn_q) begin
            dsn_pulses++;
            stb_byte = ascii;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected got=%h want=none", ascii);
            end else begin
                exp_b = exp_q.pop_front();
                if (ascii !== exp_b) begin
                    failures++;
                    $display("FAIL strobe_byte got=%h want=%h", ascii, exp_b);
                end
            end
        end
        if (!clearn && clr_q) clr_pulses++;

        if (!dsn || !clearn) begin
            low_len++;
            high_run = 0;
        end else begin
            high_run++;
        end
        dsn_q   = dsn;
        clr_q   = clearn;
        grant_q = grant;
    end

    task automatic drive(input int s, input logic [7:0] b, input logic l);
        src_valid[s]        = 1'b1;
        src_data[s*8 +: 8]  = b;
        src_last[s]         = l;
    endtask

    task automatic wait_accept(input int s, input string name);
        int n = 0;
        while (src_ready[s] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL %s accept_timeout got=%0d want<2000", name, n);
        end
        @(negedge clk);
        src_valid[s] = 1'b0;
        src_last[s]  = 1'b0;
    endtask

    task automatic put_byte(input int s, input logic [7:0] b, input logic l, input string name);
        drive(s, b, l);
        wait_accept(s, name);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy !== 1'b0 || grant !== 2'b00) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL %s idle_timeout got=%0d want<3000", name, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        #2 rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ascii, dsn, clearn, src_ready, grant, busy, drop} !== {8'h20, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got=%h/%b/%b/%b/%b/%b/%b want=20/1/1/00/00/0/0",
                     ascii, dsn, clearn, src_ready, grant, busy, drop);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({ascii, dsn, clearn, src_ready, grant, busy} !== {8'h20, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0}) begin
            failures++;
            $display("FAIL idle_after_release got=%h/%b/%b/%b/%b/%b want=20/1/1/00/00/0",
                     ascii, dsn, clearn, src_ready, grant, busy);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g[3];
`ifdef SCROLL_ARB_PRIORITY_EN
        exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b10;
        exp_q.push_back(8'h41); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
`else
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h41);
`endif
        glog.delete();
        fork
            begin
                put_byte(0, 8'h41, 1'b1, "rr_src0_a");
                put_byte(0, 8'h41, 1'b1, "rr_src0_b");
            end
            begin
                put_byte(1, 8'h42, 1'b1, "rr_src1");
            end
        join
        wait_idle("rr");
        checks++;
        if (glog.size() !== 3) begin
            failures++;
            $display("FAIL rr_grant_count got=%0d want=3", glog.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (glog[i] !== exp_g[i]) begin
                    failures++;
                    $display("FAIL rr_grant_%0d got=%b want=%b", i, glog[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_single;
        int base_d = dsn_pulses;
        int base_c = clr_pulses;
        int n = 0;
        int bad = 0;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h49);
        drive(0, 8'h48, 1'b0);
        @(negedge clk);
        checks++;
        if ({grant, busy, clearn, src_ready} !== {2'b01, 1'b1, 1'b0, 2'b00}) begin
            failures++;
            $display("FAIL grant_rise got=%b/%b/%b/%b want=01/1/0/00", grant, busy, clearn, src_ready);
        end
        wait_accept(0, "single_h");
        put_byte(0, 8'h49, 1'b1, "single_i");
        while (dsn !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (grant !== 2'b00 && n < 200) begin
            if (grant !== 2'b01) bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== GAP + HOLD) begin
            failures++;
            $display("FAIL hold_length got=%0d want=%0d", n, GAP + HOLD);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL grant_held got=%0d want=0 bad cycles", bad);
        end
        wait_idle("single");
        checks++;
        if (dsn_pulses - base_d !== 2) begin
            failures++;
            $display("FAIL single_strobes got=%0d want=2", dsn_pulses - base_d);
        end
        checks++;
        if (clr_pulses - base_c !== 1) begin
            failures++;
            $display("FAIL single_clears got=%0d want=1", clr_pulses - base_c);
        end
    endtask

    task automatic test_backspace;
        int base_d = dsn_pulses;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h08);
        put_byte(0, 8'h41, 1'b0, "bs_a");
        put_byte(0, 8'h08, 1'b1, "bs_bs");
        wait_idle("bs");
        checks++;
        if (dsn_pulses - base_d !== 2) begin
            failures++;
            $display("FAIL bs_strobes got=%0d want=2", dsn_pulses - base_d);
        end
    endtask

    task automatic test_stall;
        int bad = 0;
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h54);
        put_byte(0, 8'h53, 1'b0, "stall_s");
        repeat (10) @(negedge clk);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (src_ready !== 2'b01 || dsn !== 1'b1 || ascii !== 8'h53 ||
                grant !== 2'b01 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL stall_hold got=%0d want=0 bad cycles", bad);
        end
        put_byte(0, 8'h54, 1'b1, "stall_t");
        wait_idle("stall");
    endtask

    task automatic test_truncation;
        int base_d = dsn_pulses;
        int base_x = drop_cnt;
        for (int i = 0; i < 33; i++) begin
            logic [7:0] b;
            b = 8'(8'h61 + (i % 26));
            if (i < MAXL) exp_q.push_back(b);
            put_byte(1, b, (i == 32), "trunc");
        end
        wait_idle("trunc");
        checks++;
        if (dsn_pulses - base_d !== MAXL) begin
            failures++;
            $display("FAIL trunc_strobes got=%0d want=%0d", dsn_pulses - base_d, MAXL);
        end
        checks++;
        if (drop_cnt - base_x !== 2) begin
            failures++;
            $display("FAIL trunc_drops got=%0d want=2", drop_cnt - base_x);
        end
    endtask

    task automatic test_reset_mid_strobe;
        int n = 0;
        exp_q.push_back(8'h52);
        put_byte(0, 8'h52, 1'b0, "rst_r");
        while (dsn !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dsn !== 1'b0) begin
            failures++;
            $display("FAIL rst_strobe_seen got=%b want=0", dsn);
        end
        @(negedge clk);
        len_chk_en = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({dsn, grant, ascii, busy, clearn, src_ready} !== {1'b1, 2'b00, 8'h20, 1'b0, 1'b1, 2'b00}) begin
            failures++;
            $display("FAIL async_reset got=%b/%b/%h/%b/%b/%b want=1/00/20/0/1/00",
                     dsn, grant, ascii, busy, clearn, src_ready);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        len_chk_en = 1'b1;
        glog.delete();
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h62);
        fork
            put_byte(0, 8'h61, 1'b1, "rst_src0");
            put_byte(1, 8'h62, 1'b1, "rst_src1");
        join
        wait_idle("rst");
        checks++;
        if (glog.size() < 1 || glog[0] !== 2'b01) begin
            failures++;
            $display("FAIL first_after_reset got=%b want=01", (glog.size() > 0) ? glog[0] : 2'bxx);
        end
    endtask

    task automatic test_invariants;
        checks++;
        if (overlap_cnt !== 0) begin
            failures++;
            $display("FAIL dsn_clearn_overlap got=%0d want=0", overlap_cnt);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL missing_strobes got=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backspace();
        test_stall();
        test_truncation();
        test_reset_mid_strobe();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
